dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: m0 (core load/store unit) and m1 (loader/debug port).
- Grants one access per cycle, round-robin on ties.
- Supports a bounded lock for read-modify-write sequences.
- Registers read data into per-master response registers, giving a one-cycle read latency.
- Sits between the core/loader and the data memory's MemRead/MemWrite/addr/data_in/data_out pins.

---
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Two-master arbiter for a single-port data memory. One transfer
//             per cycle, round-robin on ties, with a bounded bus lock for
//             read-modify-write sequences and registered per-master read data
//             (one-cycle read latency).
//  Revision : 1.0 - initial release
//
//  Ports
//    clk, rst_n            clock; synchronous active-low reset
//    mX_req/we/lock        master X request, write enable, lock request
//    mX_addr/wdata         master X word address and write data
//    mX_gnt                combinational grant (transfer when req & gnt)
//    mX_rvalid/rdata       one-cycle read-valid pulse, registered read data
//    mem_read/write        memory read/write enables
//    mem_addr/wdata        memory address and write data
//    mem_rdata             combinational read data from memory
//    lock_timeout          one-cycle pulse after a forced lock release
//
//  Build option
//    DMEM_ARB_FIXED_PRIO_EN : ties in ARB always go to m0, except that the
//                             first tie after a forced release from LOCK0
//                             goes to m1.
// ============================================================================
module dmem_arbiter #(
  parameter int AW       = 6,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          lock_timeout
);

  localparam int            CW         = $clog2(LOCK_MAX);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(LOCK_MAX - 1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          timeout_q, timeout_d;
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          tie_to_m1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Set by a forced release from LOCK0; hands exactly one tie to m1.
  logic          yield_q, yield_d;
  assign tie_to_m1 = yield_q;
`else
  // Most recent winner: 0 = m0, 1 = m1. Ties go to the other master.
  logic          last_gnt_q, last_gnt_d;
  assign tie_to_m1 = ~last_gnt_q;
`endif

  logic gnt0, gnt1, xfer, win_we, win_lock;

  // Grant selection
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state_q)
      LOCK0:   gnt0 = m0_req;
      LOCK1:   gnt1 = m1_req;
      default: begin
        if (m0_req && m1_req) begin
          gnt0 = ~tie_to_m1;
          gnt1 = tie_to_m1;
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end
    endcase
  end

  assign xfer     = gnt0 | gnt1;
  assign win_we   = gnt0 ? m0_we   : m1_we;
  assign win_lock = gnt0 ? m0_lock : m1_lock;

  // Memory drive: everything forced to zero when nobody is granted
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign mem_read  = xfer & ~win_we;
  assign mem_write = xfer & win_we;
  assign mem_addr  = gnt0 ? m0_addr  : (gnt1 ? m1_addr  : '0);
  assign mem_wdata = gnt0 ? m0_wdata : (gnt1 ? m1_wdata : '0);

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    timeout_d  = 1'b0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    yield_d    = yield_q;
`else
    last_gnt_d = last_gnt_q;
    if (xfer) last_gnt_d = gnt1;
`endif
    case (state_q)
      ARB: begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        if (m0_req && m1_req) yield_d = 1'b0;
`endif
        if (xfer && win_lock) begin
          state_d    = gnt1 ? LOCK1 : LOCK0;
          lock_cnt_d = '0;
        end
      end
      LOCK0, LOCK1: begin
        lock_cnt_d = lock_cnt_q + C_CNT_ONE;
        // A voluntary unlock takes precedence over a coincident timeout.
        if (xfer && !win_lock) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == C_CNT_LAST) begin
          state_d    = ARB;
          lock_cnt_d = '0;
          timeout_d  = 1'b1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
          yield_d    = (state_q == LOCK0);
`else
          last_gnt_d = (state_q == LOCK1);
`endif
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB;
      lock_cnt_q <= '0;
      timeout_q  <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      yield_q    <= 1'b0;
`else
      last_gnt_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      timeout_q  <= timeout_d;
      rvalid0_q  <= gnt0 & ~m0_we;
      rvalid1_q  <= gnt1 & ~m1_we;
      if (gnt0 && !m0_we) rdata0_q <= mem_rdata;
      if (gnt1 && !m1_we) rdata1_q <= mem_rdata;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      yield_q    <= yield_d;
`else
      last_gnt_q <= last_gnt_d;
`endif
    end
  end

  assign m0_rvalid    = rvalid0_q;
  assign m1_rvalid    = rvalid1_q;
  assign m0_rdata     = rdata0_q;
  assign m1_rdata     = rdata1_q;
  assign lock_timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Self-checking bench for dmem_arbiter. Directed vector table,
//             hand-written lock/reset sequences and randomized traffic, all
//             compared against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int LOCK_MAX = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m0_lock = 0;
  logic [5:0]  m0_addr = 0;
  logic [31:0] m0_wdata = 0;
  logic        m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [5:0]  m1_addr = 0;
  logic [31:0] m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write, lock_timeout;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int failures = 0;

  dmem_arbiter #(.AW(6), .DW(32), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  // Single-port memory: combinational read, write at posedge.
  logic        init_mem = 1'b1;
  logic [31:0] mem [64];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h100 + i;
      mem[0] <= 32'd17; mem[1] <= 32'd9; mem[2] <= 32'd25; mem[3] <= 32'h33;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] shadow [64];
  int          m_own;      // lock owner, -1 when bus is free
  int          m_held;     // locked cycles elapsed
  int          m_tie;      // master that wins the next tie (round-robin)
  bit          m_yield;    // fixed-priority: next tie goes to m1
  logic        m_rv [2];
  logic [31:0] m_rd [2];
  logic        m_tmo;
  int          last_w;     // model's winner in the last stepped cycle

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_held = 0; m_tie = 0; m_yield = 0;
    m_rv[0] = 0; m_rv[1] = 0; m_rd[0] = 0; m_rd[1] = 0; m_tmo = 0;
  endtask

  // Called at negedge: compare the DUT against the model, then advance the
  // model by the posedge that follows.
  task automatic model_step();
    logic rq[2], we[2], lk[2];
    logic [5:0] ad[2];
    logic [31:0] wd[2];
    int w;
    bit tie;
    rq[0] = m0_req; we[0] = m0_we; lk[0] = m0_lock; ad[0] = m0_addr; wd[0] = m0_wdata;
    rq[1] = m1_req; we[1] = m1_we; lk[1] = m1_lock; ad[1] = m1_addr; wd[1] = m1_wdata;
    chk("m0_rvalid", m0_rvalid, m_rv[0]);
    chk("m1_rvalid", m1_rvalid, m_rv[1]);
    chk("m0_rdata", m0_rdata, m_rd[0]);
    chk("m1_rdata", m1_rdata, m_rd[1]);
    chk("lock_timeout", lock_timeout, m_tmo);
    if (!rst_n) begin
      model_reset();
      last_w = -1;
      return;
    end
    tie = (m_own < 0) && rq[0] && rq[1];
    if (m_own >= 0)      w = rq[m_own] ? m_own : -1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    else if (tie)        w = m_yield ? 1 : 0;
`else
    else if (tie)        w = m_tie;
`endif
    else if (rq[0])      w = 0;
    else if (rq[1])      w = 1;
    else                 w = -1;
    chk("m0_gnt", m0_gnt, w == 0);
    chk("m1_gnt", m1_gnt, w == 1);
    chk("mem_read", mem_read, (w >= 0) && !we[w >= 0 ? w : 0]);
    chk("mem_write", mem_write, (w >= 0) && we[w >= 0 ? w : 0]);
    chk("mem_addr", mem_addr, (w >= 0) ? ad[w >= 0 ? w : 0] : 6'd0);
    chk("mem_wdata", mem_wdata, (w >= 0) ? wd[w >= 0 ? w : 0] : 32'd0);
    last_w = w;
    m_rv[0] = 0; m_rv[1] = 0; m_tmo = 0;
    if (w >= 0) begin
      if (we[w]) shadow[ad[w]] = wd[w];
      else begin m_rd[w] = shadow[ad[w]]; m_rv[w] = 1; end
      m_tie = 1 - w;
    end
    if (tie) m_yield = 0;
    if (m_own < 0) begin
      if (w >= 0 && lk[w]) begin m_own = w; m_held = 0; end
    end else if (w == m_own && !lk[w]) begin
      m_own = -1;
    end else if (m_held == LOCK_MAX - 1) begin
      m_tmo = 1; m_tie = 1 - m_own; m_yield = (m_own == 0); m_own = -1;
    end else begin
      m_held++;
    end
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic r0, w0, l0, input logic [5:0] a0, input logic [31:0] d0,
                       input logic r1, w1, l1, input logic [5:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  typedef struct {
    logic r0, w0, l0; logic [5:0] a0; logic [31:0] d0;
    logic r1, w1, l1; logic [5:0] a1; logic [31:0] d1;
    logic eg0, eg1, erv0; logic [31:0] erd0; logic erv1; logic [31:0] erd1;
  } vec_t;

  vec_t tbl [13];

  // random driver state
  logic        p_req [2], p_we [2], p_lk [2];
  logic [5:0]  p_a [2];
  logic [31:0] p_d [2];

  initial begin
    int blocked, early_tmo, cnt0, cnt1;
    bit granted;
    logic tmo_at;

    for (int i = 0; i < 64; i++) shadow[i] = 32'h100 + i;
    shadow[0] = 17; shadow[1] = 9; shadow[2] = 25; shadow[3] = 32'h33;
    model_reset();
    last_w = -1;

    //        r0 w0 l0 a0 d0   r1 w1 l1 a1 d1 | g0 g1 rv0 rd0 rv1 rd1
    tbl[0]  = '{0,0,0,0,0,     0,0,0,0,0,      0,0, 0,0,   0,0};
    tbl[1]  = '{1,0,0,0,0,     1,0,0,2,0,      1,0, 0,0,   0,0};
    tbl[2]  = '{0,0,0,0,0,     1,0,0,2,0,      0,1, 1,17,  0,0};
    tbl[3]  = '{0,0,0,0,0,     0,0,0,0,0,      0,0, 0,0,   1,25};
    tbl[4]  = '{1,0,0,1,0,     0,0,0,0,0,      1,0, 0,0,   0,0};
    tbl[5]  = '{0,0,0,0,0,     0,0,0,0,0,      0,0, 1,9,   0,0};
    tbl[6]  = '{0,0,0,0,0,     1,0,0,0,0,      0,1, 0,0,   0,0};
    tbl[7]  = '{1,0,1,2,0,     1,0,0,3,0,      1,0, 0,0,   1,17};
    tbl[8]  = '{1,1,0,2,26,    1,0,0,3,0,      1,0, 1,25,  0,0};
    tbl[9]  = '{0,0,0,0,0,     1,0,0,3,0,      0,1, 0,0,   0,0};
    tbl[10] = '{0,0,0,0,0,     1,0,0,2,0,      0,1, 0,0,   1,32'h33};
    tbl[11] = '{0,0,0,0,0,     0,0,0,0,0,      0,0, 0,0,   1,26};
    tbl[12] = '{0,0,0,0,0,     0,0,0,0,0,      0,0, 0,0,   0,0};

    // reset
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin @(negedge clk); finish_cycle(); end
    rst_n = 1'b1; init_mem = 1'b0;
    @(negedge clk);
    chk("reset_m0_rdata", m0_rdata, 32'd0);
    chk("reset_m1_rdata", m1_rdata, 32'd0);
    chk("reset_lock_timeout", lock_timeout, 1'b0);
    finish_cycle();

    // directed vector table
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r0, tbl[i].w0, tbl[i].l0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].l1, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      chk($sformatf("vec%0d_m0_gnt", i), m0_gnt, tbl[i].eg0);
      chk($sformatf("vec%0d_m1_gnt", i), m1_gnt, tbl[i].eg1);
      chk($sformatf("vec%0d_m0_rvalid", i), m0_rvalid, tbl[i].erv0);
      chk($sformatf("vec%0d_m1_rvalid", i), m1_rvalid, tbl[i].erv1);
      if (tbl[i].erv0) chk($sformatf("vec%0d_m0_rdata", i), m0_rdata, tbl[i].erd0);
      if (tbl[i].erv1) chk($sformatf("vec%0d_m1_rdata", i), m1_rdata, tbl[i].erd1);
      finish_cycle();
    end

    // m1 takes the lock and idles; m0 must wait LOCK_MAX cycles
    drive(0,0,0,0,0, 1,0,1,5,0);
    @(negedge clk);
    chk("lock_take_m1_gnt", m1_gnt, 1'b1);
    finish_cycle();
    drive(1,0,0,4,0, 0,0,0,0,0);
    blocked = 0; early_tmo = 0; granted = 0; tmo_at = 0;
    for (int i = 0; i < 40 && !granted; i++) begin
      @(negedge clk);
      if (m0_gnt) begin granted = 1; tmo_at = lock_timeout; end
      else begin blocked++; if (lock_timeout) early_tmo++; end
      finish_cycle();
    end
    chk("timeout_granted", granted, 1'b1);
    chk("timeout_blocked_cycles", blocked, LOCK_MAX);
    chk("timeout_pulse_at_grant", tmo_at, 1'b1);
    chk("timeout_early_pulses", early_tmo, 0);
    drive(0,0,0,0,0, 0,0,0,0,0);
    @(negedge clk);
    chk("timeout_pulse_single", lock_timeout, 1'b0);
    finish_cycle();

    // reset while LOCK0 is active with an m0 read in flight
    drive(1,0,1,1,0, 0,0,0,0,0);
    @(negedge clk); finish_cycle();
    drive(1,0,1,0,0, 0,0,0,0,0);
    rst_n = 1'b0;
    @(negedge clk); finish_cycle();
    rst_n = 1'b1;
    drive(0,0,0,0,0, 1,0,0,2,0);
    @(negedge clk);
    chk("postrst_m1_gnt", m1_gnt, 1'b1);
    chk("postrst_m0_rvalid", m0_rvalid, 1'b0);
    chk("postrst_m0_rdata", m0_rdata, 32'd0);
    finish_cycle();
    drive(0,0,0,0,0, 0,0,0,0,0);
    @(negedge clk);
    chk("postrst_m1_rdata", m1_rdata, 32'd26);
    finish_cycle();

    // randomized traffic against the model
    for (int m = 0; m < 2; m++) begin
      p_req[m] = 0; p_we[m] = 0; p_lk[m] = 0; p_a[m] = 0; p_d[m] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (p_req[m] && last_w == m) p_req[m] = 0;
        else if (p_req[m] && $urandom_range(15) == 0) p_req[m] = 0;
        else if (!p_req[m] && $urandom_range(1) == 1) begin
          p_req[m] = 1;
          p_we[m]  = $urandom_range(1);
          p_lk[m]  = (c < 1500) ? ($urandom_range(4) == 0) : ($urandom_range(1) == 1);
          p_a[m]   = 6'($urandom_range(7));
          p_d[m]   = $urandom;
        end
      end
      drive(p_req[0], p_we[0], p_lk[0], p_a[0], p_d[0],
            p_req[1], p_we[1], p_lk[1], p_a[1], p_d[1]);
      @(negedge clk);
      finish_cycle();
    end

    // both masters request continuously out of reset
    drive(0,0,0,0,0, 0,0,0,0,0);
    rst_n = 1'b0;
    @(negedge clk); finish_cycle();
    rst_n = 1'b1;
    drive(1,0,0,0,0, 1,0,0,1,0);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt0 += int'(m0_gnt); cnt1 += int'(m1_gnt);
      finish_cycle();
    end
`ifdef DMEM_ARB_FIXED_PRIO_EN
    chk("tie_m0_grants", cnt0, 4);
    chk("tie_m1_grants", cnt1, 0);
`else
    chk("tie_m0_grants", cnt0, 2);
    chk("tie_m1_grants", cnt1, 2);
`endif
    drive(0,0,0,0,0, 0,0,0,0,0);
    @(negedge clk); finish_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
